// File: rtl/mem_access_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : mem_access_sequencer
// Brief   : Load/store initiator for the byte-addressed data RAM; splits
//           LDD/STD/SWAP into two word accesses over the MAR/MDR handshake.
// Revision: 1.0  initial release
// ============================================================================
module mem_access_sequencer #(
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 16
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Req,
    input  logic [3:0]        Op,
    input  logic [ADDR_W-1:0] Addr,
    input  logic [31:0]       StoreHi,
    input  logic [31:0]       StoreLo,
    output logic              Busy,
    output logic              Done,
    output logic [31:0]       LoadHi,
    output logic [31:0]       LoadLo,
    output logic              AlignTrap,
    output logic              IllegalOp,
    output logic              BusError,
    output logic              Mem_Enable,
    output logic              Mem_Write,
    output logic [1:0]        Mem_Size,
    output logic [ADDR_W-1:0] Mem_Address,
    output logic [31:0]       Mem_WrData,
    input  logic [31:0]       Mem_RdData,
    input  logic              Mem_Ready
);

    localparam logic [3:0] c_OP_LD   = 4'b0000;
    localparam logic [3:0] c_OP_LDUB = 4'b0001;
    localparam logic [3:0] c_OP_LDUH = 4'b0010;
    localparam logic [3:0] c_OP_LDD  = 4'b0011;
    localparam logic [3:0] c_OP_ST   = 4'b0100;
    localparam logic [3:0] c_OP_STB  = 4'b0101;
    localparam logic [3:0] c_OP_STH  = 4'b0110;
    localparam logic [3:0] c_OP_STD  = 4'b0111;
    localparam logic [3:0] c_OP_LDSB = 4'b1001;
    localparam logic [3:0] c_OP_LDSH = 4'b1010;
    localparam logic [3:0] c_OP_SWAP = 4'b1111;

    localparam logic [2:0] c_ST_IDLE = 3'd0;
    localparam logic [2:0] c_ST_ACC1 = 3'd1;
    localparam logic [2:0] c_ST_GAP  = 3'd2;
    localparam logic [2:0] c_ST_ACC2 = 3'd3;
    localparam logic [2:0] c_ST_RESP = 3'd4;

    localparam int                 c_CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT - 1);

    logic [2:0]         r_state;
    logic [3:0]         r_op;
    logic [ADDR_W-1:0]  r_addr;
    logic [31:0]        r_lo;
    logic               r_two;
    logic [c_CNT_W-1:0] r_cnt;

    logic        w_illegal;
    logic        w_misalign;
    logic        w_dword;
    logic        w_two;
    logic        w_wr1;
    logic [1:0]  w_size;
    logic [31:0] w_wrdata1;

    // Decode of the incoming request; only consumed on the accept edge.
    always_comb begin
        w_illegal = 1'b0;
        w_dword   = 1'b0;
        w_wr1     = 1'b0;
        w_size    = 2'b10;
        w_wrdata1 = '0;
        case (Op)
            c_OP_LD, c_OP_SWAP: ;
            c_OP_LDUB, c_OP_LDSB: w_size = 2'b00;
            c_OP_LDUH, c_OP_LDSH: w_size = 2'b01;
            c_OP_LDD: w_dword = 1'b1;
            c_OP_ST: begin
                w_wr1     = 1'b1;
                w_wrdata1 = StoreHi;
            end
            c_OP_STB: begin
                w_wr1     = 1'b1;
                w_size    = 2'b00;
                w_wrdata1 = {StoreHi[7:0], 24'b0};
            end
            c_OP_STH: begin
                w_wr1     = 1'b1;
                w_size    = 2'b01;
                w_wrdata1 = {StoreHi[15:0], 16'b0};
            end
            c_OP_STD: begin
                w_wr1     = 1'b1;
                w_dword   = 1'b1;
                w_wrdata1 = StoreHi;
            end
            default: w_illegal = 1'b1;
        endcase
        w_two = w_dword | (Op == c_OP_SWAP);
        if (w_dword)
            w_misalign = (Addr[2:0] != 3'b000);
        else if (w_size == 2'b10)
            w_misalign = (Addr[1:0] != 2'b00);
        else if (w_size == 2'b01)
            w_misalign = Addr[0];
        else
            w_misalign = 1'b0;
    end

    // Memory data is MSB-justified; loads right-justify and extend.
    function automatic logic [31:0] f_extend(input logic [3:0] op, input logic [31:0] rd);
        case (op)
            c_OP_LDUB: f_extend = {24'b0, rd[31:24]};
            c_OP_LDSB: f_extend = {{24{rd[31]}}, rd[31:24]};
            c_OP_LDUH: f_extend = {16'b0, rd[31:16]};
            c_OP_LDSH: f_extend = {{16{rd[31]}}, rd[31:16]};
            default:   f_extend = rd;
        endcase
    endfunction

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state     <= c_ST_IDLE;
            r_op        <= '0;
            r_addr      <= '0;
            r_lo        <= '0;
            r_two       <= 1'b0;
            r_cnt       <= '0;
            Busy        <= 1'b0;
            Done        <= 1'b0;
            LoadHi      <= '0;
            LoadLo      <= '0;
            AlignTrap   <= 1'b0;
            IllegalOp   <= 1'b0;
            BusError    <= 1'b0;
            Mem_Enable  <= 1'b0;
            Mem_Write   <= 1'b0;
            Mem_Size    <= '0;
            Mem_Address <= '0;
            Mem_WrData  <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (Req) begin
                        r_op      <= Op;
                        r_addr    <= Addr;
                        r_lo      <= StoreLo;
                        r_two     <= w_two;
                        r_cnt     <= '0;
                        Busy      <= 1'b1;
                        LoadHi    <= '0;
                        LoadLo    <= '0;
                        AlignTrap <= 1'b0;
                        IllegalOp <= 1'b0;
                        BusError  <= 1'b0;
                        if (w_illegal || w_misalign) begin
                            IllegalOp <= w_illegal;
                            AlignTrap <= ~w_illegal;
                            Done      <= 1'b1;
                            r_state   <= c_ST_RESP;
                        end else begin
                            Mem_Enable  <= 1'b1;
                            Mem_Write   <= w_wr1;
                            Mem_Size    <= w_size;
                            Mem_Address <= Addr;
                            Mem_WrData  <= w_wrdata1;
                            r_state     <= c_ST_ACC1;
                        end
                    end
                end
                c_ST_ACC1, c_ST_ACC2: begin
                    if (Mem_Ready) begin
                        if (!Mem_Write) begin
                            if (r_state == c_ST_ACC1)
                                LoadHi <= f_extend(r_op, Mem_RdData);
                            else
                                LoadLo <= Mem_RdData;
                        end
                        Mem_Enable  <= 1'b0;
                        Mem_Write   <= 1'b0;
                        Mem_Size    <= '0;
                        Mem_Address <= '0;
                        Mem_WrData  <= '0;
                        if (r_state == c_ST_ACC1 && r_two) begin
                            r_state <= c_ST_GAP;
                        end else begin
                            Done    <= 1'b1;
                            r_state <= c_ST_RESP;
                        end
                    end else if (r_cnt == c_CNT_LAST) begin
                        Mem_Enable  <= 1'b0;
                        Mem_Write   <= 1'b0;
                        Mem_Size    <= '0;
                        Mem_Address <= '0;
                        Mem_WrData  <= '0;
                        LoadHi      <= '0;
                        LoadLo      <= '0;
                        BusError    <= 1'b1;
                        Done        <= 1'b1;
                        r_state     <= c_ST_RESP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                // The RAM acts on Enable edges, so Enable stays low here for one cycle.
                c_ST_GAP: begin
                    r_cnt      <= '0;
                    Mem_Enable <= 1'b1;
                    Mem_Size   <= 2'b10;
                    if (r_op == c_OP_SWAP) begin
                        Mem_Write   <= 1'b1;
                        Mem_Address <= r_addr;
                        Mem_WrData  <= r_lo;
                    end else begin
                        Mem_Write   <= (r_op == c_OP_STD);
                        Mem_Address <= r_addr + ADDR_W'(4);
                        Mem_WrData  <= (r_op == c_OP_STD) ? r_lo : 32'h0;
                    end
                    r_state <= c_ST_ACC2;
                end
                c_ST_RESP: begin
                    Done    <= 1'b0;
                    Busy    <= 1'b0;
                    r_state <= c_ST_IDLE;
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_mem_access_sequencer
// Brief   : Directed self-checking bench with a byte-array RAM model.
// Revision: 1.0  initial release
// ============================================================================
module tb_mem_access_sequencer;

    logic        Clk = 1'b0;
    logic        Reset, Req;
    logic [3:0]  Op;
    logic [7:0]  Addr;
    logic [31:0] StoreHi, StoreLo;
    logic        Busy, Done, AlignTrap, IllegalOp, BusError;
    logic [31:0] LoadHi, LoadLo;
    logic        Mem_Enable, Mem_Write, Mem_Ready;
    logic [1:0]  Mem_Size;
    logic [7:0]  Mem_Address;
    logic [31:0] Mem_WrData, Mem_RdData;

    mem_access_sequencer #(.ADDR_W(8), .TIMEOUT(16)) dut (
        .Clk(Clk), .Reset(Reset), .Req(Req), .Op(Op), .Addr(Addr),
        .StoreHi(StoreHi), .StoreLo(StoreLo), .Busy(Busy), .Done(Done),
        .LoadHi(LoadHi), .LoadLo(LoadLo), .AlignTrap(AlignTrap),
        .IllegalOp(IllegalOp), .BusError(BusError), .Mem_Enable(Mem_Enable),
        .Mem_Write(Mem_Write), .Mem_Size(Mem_Size), .Mem_Address(Mem_Address),
        .Mem_WrData(Mem_WrData), .Mem_RdData(Mem_RdData), .Mem_Ready(Mem_Ready)
    );

    always #5 Clk = ~Clk;

    // RAM model: big-endian bytes, MSB-justified read data, zero-wait ready.
    logic [7:0]  mem [256];
    logic        rdy_en;
    logic        pl_en;
    logic [7:0]  pl_addr;
    logic [31:0] pl_data;
    assign Mem_Ready  = Mem_Enable & rdy_en;
    assign Mem_RdData = {mem[Mem_Address], mem[Mem_Address + 8'd1],
                         mem[Mem_Address + 8'd2], mem[Mem_Address + 8'd3]};

    int          cyc = 0, n_acc = 0, en_rises = 0;
    logic        en_d = 1'b0;
    logic [7:0]  acc_addr [64];
    logic        acc_wr   [64];
    logic [1:0]  acc_size [64];
    logic [31:0] acc_data [64];
    int          acc_cyc  [64];

    always @(posedge Clk) begin
        cyc  <= cyc + 1;
        en_d <= Mem_Enable;
        if (Mem_Enable && !en_d) en_rises <= en_rises + 1;
        if (pl_en) begin
            mem[pl_addr]        <= pl_data[31:24];
            mem[pl_addr + 8'd1] <= pl_data[23:16];
            mem[pl_addr + 8'd2] <= pl_data[15:8];
            mem[pl_addr + 8'd3] <= pl_data[7:0];
        end
        if (Mem_Enable && Mem_Ready) begin
            if (n_acc < 64) begin
                acc_addr[n_acc] <= Mem_Address;
                acc_wr[n_acc]   <= Mem_Write;
                acc_size[n_acc] <= Mem_Size;
                acc_data[n_acc] <= Mem_WrData;
                acc_cyc[n_acc]  <= cyc;
            end
            n_acc <= n_acc + 1;
            if (Mem_Write) begin
                mem[Mem_Address] <= Mem_WrData[31:24];
                if (Mem_Size != 2'b00) mem[Mem_Address + 8'd1] <= Mem_WrData[23:16];
                if (Mem_Size == 2'b10) begin
                    mem[Mem_Address + 8'd2] <= Mem_WrData[15:8];
                    mem[Mem_Address + 8'd3] <= Mem_WrData[7:0];
                end
            end
        end
    end

    int n_cmp = 0, n_err = 0;

    task automatic preload(input logic [7:0] a, input logic [31:0] d);
        @(negedge Clk); pl_addr = a; pl_data = d; pl_en = 1'b1;
        @(negedge Clk); pl_en = 1'b0;
    endtask

    // lat counts clock edges from the accept edge (inclusive) until Done is seen.
    task automatic run_op(input logic [3:0] op, input logic [7:0] a,
                          input logic [31:0] hi, input logic [31:0] lo, output int lat);
        @(negedge Clk); Req = 1'b1; Op = op; Addr = a; StoreHi = hi; StoreLo = lo;
        @(posedge Clk); lat = 1;
        @(negedge Clk); Req = 1'b0;
        while (!Done && lat < 60) begin
            @(posedge Clk); lat++;
            @(negedge Clk);
        end
        if (!Done) begin
            n_cmp++; n_err++;
            $display("FAIL done_wait op=%b got no Done within %0d cycles", op, lat);
        end
    endtask

    task automatic test_reset();
        n_cmp++; if (Busy !== 1'b0) begin n_err++; $display("FAIL rst_busy got %b want 0", Busy); end
        n_cmp++; if (Done !== 1'b0) begin n_err++; $display("FAIL rst_done got %b want 0", Done); end
        n_cmp++; if (Mem_Enable !== 1'b0) begin n_err++; $display("FAIL rst_en got %b want 0", Mem_Enable); end
        n_cmp++; if (LoadHi !== 32'h0) begin n_err++; $display("FAIL rst_loadhi got %h want 0", LoadHi); end
    endtask

    task automatic test_load_extend();
        int lat, a0;
        preload(8'h04, 32'h0080_0000);
        a0 = n_acc;
        run_op(4'b1001, 8'h05, 32'h0, 32'h0, lat);
        n_cmp++; if (LoadHi !== 32'hFFFF_FF80) begin n_err++; $display("FAIL ldsb_data got %h want ffffff80", LoadHi); end
        n_cmp++; if (lat !== 2) begin n_err++; $display("FAIL ldsb_latency got %0d want 2", lat); end
        n_cmp++; if (n_acc !== a0 + 1) begin n_err++; $display("FAIL ldsb_count got %0d want %0d", n_acc, a0 + 1); end
        n_cmp++; if ({acc_addr[a0], acc_size[a0], acc_wr[a0]} !== {8'h05, 2'b00, 1'b0})
            begin n_err++; $display("FAIL ldsb_access got a=%h s=%b w=%b want a=05 s=00 w=0", acc_addr[a0], acc_size[a0], acc_wr[a0]); end
        run_op(4'b0001, 8'h05, 32'h0, 32'h0, lat);
        n_cmp++; if (LoadHi !== 32'h0000_0080) begin n_err++; $display("FAIL ldub_data got %h want 00000080", LoadHi); end
    endtask

    task automatic test_align();
        int lat, a0, r0;
        preload(8'h00, 32'h0000_BEEF);
        a0 = n_acc; r0 = en_rises;
        run_op(4'b0010, 8'h03, 32'h0, 32'h0, lat);
        n_cmp++; if ({AlignTrap, IllegalOp} !== 2'b10) begin n_err++; $display("FAIL ldudh_trap got at=%b il=%b want at=1 il=0", AlignTrap, IllegalOp); end
        n_cmp++; if (lat !== 1) begin n_err++; $display("FAIL trap_latency got %0d want 1", lat); end
        n_cmp++; if (n_acc !== a0 || en_rises !== r0) begin n_err++; $display("FAIL trap_noaccess got acc=%0d rises=%0d want %0d/%0d", n_acc, en_rises, a0, r0); end
        run_op(4'b0010, 8'h02, 32'h0, 32'h0, lat);
        n_cmp++; if (LoadHi !== 32'h0000_BEEF) begin n_err++; $display("FAIL lduh_data got %h want 0000beef", LoadHi); end
        n_cmp++; if (AlignTrap !== 1'b0) begin n_err++; $display("FAIL lduh_trapclr got %b want 0", AlignTrap); end
        run_op(4'b1010, 8'h02, 32'h0, 32'h0, lat);
        n_cmp++; if (LoadHi !== 32'hFFFF_BEEF) begin n_err++; $display("FAIL ldsh_data got %h want ffffbeef", LoadHi); end
        run_op(4'b1101, 8'h03, 32'h0, 32'h0, lat);
        n_cmp++; if ({AlignTrap, IllegalOp} !== 2'b01) begin n_err++; $display("FAIL illegal_prio got at=%b il=%b want at=0 il=1", AlignTrap, IllegalOp); end
        run_op(4'b0011, 8'h04, 32'h0, 32'h0, lat);
        n_cmp++; if ({AlignTrap, IllegalOp} !== 2'b10) begin n_err++; $display("FAIL ldd_align got at=%b il=%b want at=1 il=0", AlignTrap, IllegalOp); end
    endtask

    task automatic test_back_to_back();
        int lat, a0, r0;
        a0 = n_acc; r0 = en_rises;
        run_op(4'b0111, 8'h10, 32'h1122_3344, 32'h5566_7788, lat);
        n_cmp++; if (lat !== 4) begin n_err++; $display("FAIL std_latency got %0d want 4", lat); end
        n_cmp++; if ({acc_addr[a0], acc_wr[a0], acc_data[a0]} !== {8'h10, 1'b1, 32'h1122_3344})
            begin n_err++; $display("FAIL std_first got a=%h w=%b d=%h want a=10 w=1 d=11223344", acc_addr[a0], acc_wr[a0], acc_data[a0]); end
        n_cmp++; if ({acc_addr[a0+1], acc_wr[a0+1], acc_data[a0+1]} !== {8'h14, 1'b1, 32'h5566_7788})
            begin n_err++; $display("FAIL std_second got a=%h w=%b d=%h want a=14 w=1 d=55667788", acc_addr[a0+1], acc_wr[a0+1], acc_data[a0+1]); end
        n_cmp++; if (acc_cyc[a0+1] - acc_cyc[a0] !== 2 || en_rises - r0 !== 2)
            begin n_err++; $display("FAIL std_gap got spacing=%0d rises=%0d want 2/2", acc_cyc[a0+1] - acc_cyc[a0], en_rises - r0); end
        run_op(4'b0011, 8'h10, 32'h0, 32'h0, lat);
        n_cmp++; if ({LoadHi, LoadLo} !== {32'h1122_3344, 32'h5566_7788})
            begin n_err++; $display("FAIL ldd_data got %h_%h want 11223344_55667788", LoadHi, LoadLo); end
        a0 = n_acc;
        run_op(4'b0101, 8'h31, 32'hDEAD_BEAB, 32'h0, lat);
        n_cmp++; if ({acc_size[a0], acc_data[a0]} !== {2'b00, 32'hAB00_0000})
            begin n_err++; $display("FAIL stb_pack got s=%b d=%h want s=00 d=ab000000", acc_size[a0], acc_data[a0]); end
        run_op(4'b0110, 8'h32, 32'hFFFF_1234, 32'h0, lat);
        n_cmp++; if ({acc_size[a0+1], acc_data[a0+1]} !== {2'b01, 32'h1234_0000})
            begin n_err++; $display("FAIL sth_pack got s=%b d=%h want s=01 d=12340000", acc_size[a0+1], acc_data[a0+1]); end
        run_op(4'b0001, 8'h31, 32'h0, 32'h0, lat);
        n_cmp++; if (LoadHi !== 32'h0000_00AB) begin n_err++; $display("FAIL stb_readback got %h want 000000ab", LoadHi); end
        run_op(4'b0010, 8'h32, 32'h0, 32'h0, lat);
        n_cmp++; if (LoadHi !== 32'h0000_1234) begin n_err++; $display("FAIL sth_readback got %h want 00001234", LoadHi); end
    endtask

    task automatic test_swap();
        int lat, a0;
        preload(8'h20, 32'hCAFE_F00D);
        a0 = n_acc;
        run_op(4'b1111, 8'h20, 32'h0BAD_0BAD, 32'h1234_5678, lat);
        n_cmp++; if (LoadHi !== 32'hCAFE_F00D) begin n_err++; $display("FAIL swap_old got %h want cafef00d", LoadHi); end
        n_cmp++; if (lat !== 4) begin n_err++; $display("FAIL swap_latency got %0d want 4", lat); end
        n_cmp++; if ({acc_addr[a0], acc_wr[a0], acc_addr[a0+1], acc_wr[a0+1], acc_data[a0+1]} !== {8'h20, 1'b0, 8'h20, 1'b1, 32'h1234_5678})
            begin n_err++; $display("FAIL swap_seq got %h/%b %h/%b %h want 20/0 20/1 12345678", acc_addr[a0], acc_wr[a0], acc_addr[a0+1], acc_wr[a0+1], acc_data[a0+1]); end
        run_op(4'b0000, 8'h20, 32'h0, 32'h0, lat);
        n_cmp++; if (LoadHi !== 32'h1234_5678) begin n_err++; $display("FAIL swap_readback got %h want 12345678", LoadHi); end
    endtask

    task automatic test_timeout();
        int lat;
        rdy_en = 1'b0;
        @(negedge Clk); Req = 1'b1; Op = 4'b0000; Addr = 8'h40;
        @(posedge Clk); lat = 1;
        @(negedge Clk); Op = 4'b0100; Addr = 8'h50; StoreHi = 32'hFFFF_FFFF;
        repeat (5) begin @(posedge Clk); lat++; @(negedge Clk); end
        Req = 1'b0;
        n_cmp++; if ({Busy, Mem_Enable, Mem_Write, Mem_Address} !== {1'b1, 1'b1, 1'b0, 8'h40})
            begin n_err++; $display("FAIL busy_ignore got b=%b e=%b w=%b a=%h want 1 1 0 40", Busy, Mem_Enable, Mem_Write, Mem_Address); end
        while (!Done && lat < 60) begin @(posedge Clk); lat++; @(negedge Clk); end
        n_cmp++; if (lat !== 17) begin n_err++; $display("FAIL timeout_latency got %0d want 17", lat); end
        n_cmp++; if ({Done, BusError, LoadHi} !== {1'b1, 1'b1, 32'h0})
            begin n_err++; $display("FAIL bus_error got d=%b be=%b lh=%h want 1 1 0", Done, BusError, LoadHi); end
        @(posedge Clk); @(negedge Clk);
        n_cmp++; if ({Busy, Done} !== 2'b00) begin n_err++; $display("FAIL post_resp got b=%b d=%b want 0 0", Busy, Done); end
        rdy_en = 1'b1;
    endtask

    task automatic test_reset_mid();
        int lat;
        @(negedge Clk); Req = 1'b1; Op = 4'b0011; Addr = 8'h10;
        @(posedge Clk); @(negedge Clk); Req = 1'b0;
        @(posedge Clk); @(negedge Clk); rdy_en = 1'b0;
        n_cmp++; if ({Mem_Enable, LoadHi} !== {1'b0, 32'h1122_3344})
            begin n_err++; $display("FAIL ldd_gap got e=%b lh=%h want 0 11223344", Mem_Enable, LoadHi); end
        @(posedge Clk); @(negedge Clk);
        n_cmp++; if ({Mem_Enable, Mem_Address} !== {1'b1, 8'h14})
            begin n_err++; $display("FAIL ldd_acc2 got e=%b a=%h want 1 14", Mem_Enable, Mem_Address); end
        Reset = 1'b1;
        @(posedge Clk); @(negedge Clk);
        n_cmp++; if ({Busy, Done, Mem_Enable, Mem_Address, LoadHi, LoadLo} !== '0)
            begin n_err++; $display("FAIL mid_reset got b=%b d=%b e=%b a=%h lh=%h ll=%h want all 0", Busy, Done, Mem_Enable, Mem_Address, LoadHi, LoadLo); end
        Reset = 1'b0; rdy_en = 1'b1;
        run_op(4'b0000, 8'h14, 32'h0, 32'h0, lat);
        n_cmp++; if ({LoadHi, BusError} !== {32'h5566_7788, 1'b0})
            begin n_err++; $display("FAIL after_reset_ld got lh=%h be=%b want 55667788 0", LoadHi, BusError); end
        n_cmp++; if (lat !== 2) begin n_err++; $display("FAIL after_reset_latency got %0d want 2", lat); end
    endtask

    initial begin
        Reset = 1'b1; Req = 1'b0; Op = '0; Addr = '0; StoreHi = '0; StoreLo = '0;
        rdy_en = 1'b1; pl_en = 1'b0; pl_addr = '0; pl_data = '0;
        repeat (3) @(posedge Clk);
        @(negedge Clk); Reset = 1'b0;
        test_reset();
        test_load_extend();
        test_align();
        test_back_to_back();
        test_swap();
        test_timeout();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got no completion want finish before 200000");
        $fatal(1);
    end

endmodule
`default_nettype wire
